// File: rtl/slave_port_gen2_if.sv
// Serial master/slave bus between the arbiter mux and one slave port.
// Carries request enables, serial header/data bits and the handshake/split strobes.
interface slave_port_gen2_if;
  logic read_enable;
  logic write_enable;
  logic m_valid;
  logic m_ready;
  logic rx_address;
  logic rx_burst;
  logic rx_data;
  logic s_ready;
  logic s_valid;
  logic tx_data;
  logic split_enable;

  modport slave (
    input  read_enable, write_enable, m_valid, m_ready, rx_address, rx_burst, rx_data,
    output s_ready, s_valid, tx_data, split_enable
  );

  modport master (
    output read_enable, write_enable, m_valid, m_ready, rx_address, rx_burst, rx_data,
    input  s_ready, s_valid, tx_data, split_enable
  );
endinterface

// File: rtl/slave_port_gen2.sv
// Serial-bus slave port: deserialises header and write beats, drives a single-cycle
// memory, serialises read beats, and splits for slow slaves and at burst-beat boundaries.
module slave_port_gen2 #(
  parameter int unsigned ADDR_W      = 12,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned BURST_W     = 12,
  parameter int unsigned SPLIT_BEAT  = 8,
  parameter int unsigned SLOW_THRESH = 5,
  parameter int unsigned DELAY_W     = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [DELAY_W-1:0]  slave_delay,
  slave_port_gen2_if.slave    bus,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                mem_we,
  output logic                mem_re,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int unsigned BF_W       = BURST_W + 1;
  localparam int unsigned HDR_LEN    = (ADDR_W > BF_W) ? ADDR_W : BF_W;
  localparam int unsigned HDR_CW     = $clog2(HDR_LEN);
  localparam int unsigned BIT_CW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned SPLIT_MASK = SPLIT_BEAT - 1;

  typedef enum logic [2:0] {IDLE, HDR, WDATA, WMEM, SPLIT, RMEM, RCAP, RDATA} state_t;

  state_t              state;
  logic                op_write;
  logic [ADDR_W-1:0]   addr_sr;
  logic [BF_W-1:0]     burst_sr;
  logic [HDR_CW-1:0]   hdr_idx;
  logic [BURST_W-1:0]  beat_idx;
  logic [BURST_W-1:0]  beat_last;
  logic [DATA_W-1:0]   data_sr;
  logic [BIT_CW-1:0]   bit_cnt;
  logic [DELAY_W-1:0]  dly_cnt;

  logic [ADDR_W-1:0]   addr_nxt;
  logic [BF_W-1:0]     burst_nxt;
  logic [DELAY_W-1:0]  dly_init;
  logic [BURST_W-1:0]  beat_inc;
  logic                bit_last;
  logic                is_last;
  logic                at_split;
  logic                beat_end;

  // Header bits land at their index; beat-completion decode shared by write and read paths.
  always_comb begin
    addr_nxt  = addr_sr | (ADDR_W'(bus.rx_address) << hdr_idx);
    burst_nxt = burst_sr | (BF_W'(bus.rx_burst) << hdr_idx);
    dly_init  = (slave_delay == '0) ? DELAY_W'(1) : slave_delay;
    beat_inc  = beat_idx + BURST_W'(1);
    bit_last  = (bit_cnt == BIT_CW'(DATA_W - 1));
    is_last   = (beat_idx == beat_last);
    at_split  = ((beat_inc & BURST_W'(SPLIT_MASK)) == '0);
    beat_end  = (state == WMEM) || ((state == RDATA) && bus.m_ready && bit_last);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state            <= IDLE;
      op_write         <= 1'b0;
      addr_sr          <= '0;
      burst_sr         <= '0;
      hdr_idx          <= '0;
      beat_idx         <= '0;
      beat_last        <= '0;
      data_sr          <= '0;
      bit_cnt          <= '0;
      dly_cnt          <= '0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      mem_we           <= 1'b0;
      mem_re           <= 1'b0;
      bus.s_ready      <= 1'b0;
      bus.s_valid      <= 1'b0;
      bus.tx_data      <= 1'b0;
      bus.split_enable <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      case (state)
        IDLE: begin
          bus.s_ready <= 1'b1;
          bus.tx_data <= 1'b0;
          if (bus.m_valid && (bus.read_enable ^ bus.write_enable)) begin
            op_write <= bus.write_enable;
            addr_sr  <= ADDR_W'(bus.rx_address);
            burst_sr <= BF_W'(bus.rx_burst);
            hdr_idx  <= HDR_CW'(1);
            state    <= HDR;
          end
        end
        HDR: begin
          if (bus.m_valid) begin
            addr_sr  <= addr_nxt;
            burst_sr <= burst_nxt;
            hdr_idx  <= hdr_idx + HDR_CW'(1);
            if (hdr_idx == HDR_CW'(HDR_LEN - 1)) begin
              mem_addr  <= addr_nxt;
              beat_idx  <= '0;
              beat_last <= burst_nxt[0] ? burst_nxt[BURST_W:1] : '0;
              bit_cnt   <= '0;
              if (op_write) begin
                state <= WDATA;
              end else begin
                bus.s_ready <= 1'b0;
                if (slave_delay >= DELAY_W'(SLOW_THRESH)) begin
                  state            <= SPLIT;
                  bus.split_enable <= 1'b1;
                  dly_cnt          <= dly_init;
                end else begin
                  state  <= RMEM;
                  mem_re <= 1'b1;
                end
              end
            end
          end
        end
        WDATA: begin
          if (bus.m_valid) begin
            data_sr <= {bus.rx_data, data_sr[DATA_W-1:1]};
            bit_cnt <= bit_cnt + BIT_CW'(1);
            if (bit_last) begin
              mem_wdata   <= {bus.rx_data, data_sr[DATA_W-1:1]};
              mem_we      <= 1'b1;
              bus.s_ready <= 1'b0;
              bit_cnt     <= '0;
              state       <= WMEM;
            end
          end
        end
        WMEM: ;
        SPLIT: begin
          if (dly_cnt <= DELAY_W'(1)) begin
            bus.split_enable <= 1'b0;
            if (op_write) begin
              state       <= WDATA;
              bus.s_ready <= 1'b1;
            end else begin
              state  <= RMEM;
              mem_re <= 1'b1;
            end
          end else begin
            dly_cnt <= dly_cnt - DELAY_W'(1);
          end
        end
        RMEM: state <= RCAP;
        RCAP: begin
          data_sr     <= mem_rdata >> 1;
          bus.tx_data <= mem_rdata[0];
          bus.s_valid <= 1'b1;
          bit_cnt     <= '0;
          state       <= RDATA;
        end
        RDATA: begin
          if (bus.m_ready) begin
            if (bit_last) begin
              bus.s_valid <= 1'b0;
              bus.tx_data <= 1'b0;
            end else begin
              bus.tx_data <= data_sr[0];
              data_sr     <= data_sr >> 1;
              bit_cnt     <= bit_cnt + BIT_CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      // Completed beat: finish, split at the beat boundary, or move to the next beat.
      if (beat_end) begin
        beat_idx <= beat_inc;
        bit_cnt  <= '0;
        if (is_last) begin
          state       <= IDLE;
          bus.s_ready <= 1'b1;
        end else begin
          mem_addr <= mem_addr + ADDR_W'(1);
          if (at_split) begin
            state            <= SPLIT;
            bus.split_enable <= 1'b1;
            dly_cnt          <= dly_init;
          end else if (op_write) begin
            state       <= WDATA;
            bus.s_ready <= 1'b1;
          end else begin
            state  <= RMEM;
            mem_re <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_slave_port_gen2.sv
// Directed bench for slave_port_gen2: serial master driver, memory model and per-scenario checks.
module tb_slave_port_gen2;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [5:0]  slave_delay;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_we, mem_re;

  slave_port_gen2_if bus();

  slave_port_gen2 dut (
    .clk(clk), .rstn(rstn), .slave_delay(slave_delay), .bus(bus),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Memory model: unwritten locations read as addr[7:0] ^ 8'h5A.
  logic [7:0]  mem [0:4095];
  bit          wr_valid [0:4095];
  logic [11:0] we_addr[$], re_addr[$];
  logic [7:0]  we_data[$];
  int          split_cnt = 0, split_runs = 0, split_at_we = 0;
  logic        split_prev = 1'b0;
  logic [7:0]  wq[$], rq[$];

  always @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr]      <= mem_wdata;
      wr_valid[mem_addr] <= 1'b1;
      we_addr.push_back(mem_addr);
      we_data.push_back(mem_wdata);
    end
    if (mem_re) begin
      mem_rdata <= wr_valid[mem_addr] ? mem[mem_addr] : (mem_addr[7:0] ^ 8'h5A);
      re_addr.push_back(mem_addr);
    end
    if (bus.split_enable) split_cnt <= split_cnt + 1;
    if (bus.split_enable && !split_prev) begin
      split_runs  <= split_runs + 1;
      split_at_we <= we_data.size();
    end
    split_prev <= bus.split_enable;
  end

  task automatic send_header(input bit wr, input logic [11:0] addr, input bit flag,
                             input logic [11:0] cm1, input bit stall);
    logic [12:0] ab, hb;
    int i, c;
    ab = {1'b0, addr};
    hb = {cm1, flag};
    i = 0;
    c = 0;
    while (i < 13) begin
      @(negedge clk);
      c++;
      bus.read_enable  = (i == 0) ? !wr : 1'b0;
      bus.write_enable = (i == 0) ? wr : 1'b0;
      if (stall && i > 0 && c[0]) begin
        bus.m_valid    = 1'b0;
        bus.rx_address = ~ab[0];
        bus.rx_burst   = ~hb[0];
      end else begin
        bus.m_valid    = 1'b1;
        bus.rx_address = ab[0];
        bus.rx_burst   = hb[0];
        ab = ab >> 1;
        hb = hb >> 1;
        i++;
      end
    end
  endtask

  task automatic write_data();
    logic [7:0] d;
    int t;
    foreach (wq[k]) begin
      d = wq[k];
      @(negedge clk);
      bus.m_valid = 1'b0;
      t = 0;
      while (bus.s_ready !== 1'b1 && t < 100) begin
        @(negedge clk);
        t++;
      end
      if (t >= 100) begin
        checks++;
        $display("FAIL write_wait: s_ready timeout at beat %0d, got %b required 1", k, bus.s_ready);
        return;
      end
      for (int j = 0; j < 8; j++) begin
        if (j > 0) @(negedge clk);
        bus.m_valid = 1'b1;
        bus.rx_data = d[0];
        d = d >> 1;
      end
    end
    @(negedge clk);
    bus.m_valid = 1'b0;
  endtask

  task automatic recv(input int nbytes, input bit stall, output int lat);
    int cyc, bits;
    logic [7:0] cur;
    bit rdy;
    cyc = 0;
    bits = 0;
    cur = '0;
    lat = -1;
    rq.delete();
    while (bits < nbytes * 8 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      bus.m_valid = 1'b0;
      if (bus.s_valid === 1'b1 && lat < 0) lat = cyc;
      rdy = stall ? cyc[0] : 1'b1;
      bus.m_ready = rdy;
      if (rdy && bus.s_valid === 1'b1) begin
        cur = {bus.tx_data, cur[7:1]};
        bits++;
        if (bits % 8 == 0) rq.push_back(cur);
      end
    end
    @(negedge clk);
    bus.m_ready = 1'b0;
    checks++;
    if (bus.s_valid !== 1'b0 || bits != nbytes * 8)
      $display("FAIL recv_end: s_valid=%b bits=%0d, required s_valid=0 bits=%0d", bus.s_valid, bits, nbytes * 8);
    else passed++;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({bus.s_ready, bus.s_valid, bus.tx_data, bus.split_enable, mem_we, mem_re} !== 6'b0)
      $display("FAIL reset_ctrl: got %b required 000000",
               {bus.s_ready, bus.s_valid, bus.tx_data, bus.split_enable, mem_we, mem_re});
    else passed++;
    checks++;
    if ({mem_addr, mem_wdata} !== 20'h0)
      $display("FAIL reset_bus: got %h required 00000", {mem_addr, mem_wdata});
    else passed++;
    rstn = 1'b1;
    #1;
    checks++;
    if (bus.s_ready !== 1'b0) $display("FAIL reset_release: s_ready got %b required 0", bus.s_ready);
    else passed++;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1) $display("FAIL reset_sready: got %b required 1", bus.s_ready);
    else passed++;
  endtask

  task automatic test_single_write();
    int bw, bs;
    bw = we_addr.size();
    bs = split_cnt;
    slave_delay = 6'd0;
    @(negedge clk);
    bus.m_valid = 1'b1; bus.read_enable = 1'b1; bus.write_enable = 1'b1;
    bus.rx_address = 1'b1; bus.rx_burst = 1'b1;
    @(negedge clk);
    bus.m_valid = 1'b0; bus.read_enable = 1'b0; bus.write_enable = 1'b0;
    send_header(1'b1, 12'h123, 1'b0, 12'h005, 1'b0);
    wq = '{8'hA5};
    write_data();
    repeat (4) @(negedge clk);
    checks++;
    if (we_addr.size() - bw != 1) $display("FAIL sw_count: got %0d required 1", we_addr.size() - bw);
    else passed++;
    checks++;
    if (we_addr[bw] !== 12'h123) $display("FAIL sw_addr: got %h required 123", we_addr[bw]);
    else passed++;
    checks++;
    if (we_data[bw] !== 8'hA5) $display("FAIL sw_data: got %h required a5", we_data[bw]);
    else passed++;
    checks++;
    if (bus.s_ready !== 1'b1 || split_cnt != bs)
      $display("FAIL sw_idle: s_ready=%b splits=%0d required 1 and 0", bus.s_ready, split_cnt - bs);
    else passed++;
  endtask

  task automatic test_read_burst(input bit stall);
    int br, bs, lat;
    logic [7:0] exp_b [3];
    exp_b = '{8'h4A, 8'h4B, 8'h48};
    br = re_addr.size();
    bs = split_cnt;
    slave_delay = 6'd2;
    send_header(1'b0, 12'h010, 1'b1, 12'd2, stall);
    recv(3, stall, lat);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (rq.size() <= k || rq[k] !== exp_b[k])
        $display("FAIL rb_data%0d (stall=%0d): got %h required %h", k, stall, (rq.size() > k) ? rq[k] : 8'hxx, exp_b[k]);
      else passed++;
      checks++;
      if (re_addr.size() <= br + k || re_addr[br + k] !== 12'h010 + 12'(k))
        $display("FAIL rb_addr%0d: got %h required %h", k, (re_addr.size() > br + k) ? re_addr[br + k] : 12'hxxx, 12'h010 + 12'(k));
      else passed++;
    end
    checks++;
    if (split_cnt != bs) $display("FAIL rb_split: got %0d cycles required 0", split_cnt - bs);
    else passed++;
    if (!stall) begin
      checks++;
      if (lat != 3) $display("FAIL rb_latency: got %0d required 3", lat);
      else passed++;
    end
  endtask

  task automatic test_slow_read();
    int bs, bn, lat;
    bs = split_cnt;
    bn = split_runs;
    slave_delay = 6'd7;
    send_header(1'b0, 12'h200, 1'b0, 12'h000, 1'b0);
    recv(1, 1'b0, lat);
    checks++;
    if (split_cnt - bs != 7 || split_runs - bn != 1)
      $display("FAIL slow_split: got %0d cycles %0d runs required 7 and 1", split_cnt - bs, split_runs - bn);
    else passed++;
    checks++;
    if (lat != 10) $display("FAIL slow_latency: got %0d required 10", lat);
    else passed++;
    checks++;
    if (rq.size() != 1 || rq[0] !== 8'h5A) $display("FAIL slow_data: got %h required 5a", rq[0]);
    else passed++;
  endtask

  task automatic test_write_burst();
    int bw, bs, bn;
    bw = we_addr.size();
    bs = split_cnt;
    bn = split_runs;
    slave_delay = 6'd3;
    send_header(1'b1, 12'h040, 1'b1, 12'd9, 1'b0);
    wq.delete();
    for (int k = 0; k < 10; k++) wq.push_back(8'h10 + 8'(k));
    write_data();
    repeat (6) @(negedge clk);
    checks++;
    if (we_addr.size() - bw != 10) $display("FAIL wb_count: got %0d required 10", we_addr.size() - bw);
    else passed++;
    checks++;
    if (split_cnt - bs != 3 || split_runs - bn != 1)
      $display("FAIL wb_split: got %0d cycles %0d runs required 3 and 1", split_cnt - bs, split_runs - bn);
    else passed++;
    checks++;
    if (split_at_we - bw != 8) $display("FAIL wb_split_pos: got after %0d beats required 8", split_at_we - bw);
    else passed++;
    checks++;
    if (we_addr[bw + 8] !== 12'h048 || we_addr[bw + 9] !== 12'h049)
      $display("FAIL wb_addr: got %h %h required 048 049", we_addr[bw + 8], we_addr[bw + 9]);
    else passed++;
    checks++;
    if (we_data[bw] !== 8'h10 || we_data[bw + 9] !== 8'h19)
      $display("FAIL wb_data: got %h %h required 10 19", we_data[bw], we_data[bw + 9]);
    else passed++;
  endtask

  task automatic test_wrap();
    int br, lat;
    br = re_addr.size();
    slave_delay = 6'd0;
    send_header(1'b0, 12'hFFF, 1'b1, 12'd1, 1'b0);
    recv(2, 1'b0, lat);
    checks++;
    if (re_addr.size() != br + 2 || re_addr[br] !== 12'hFFF || re_addr[br + 1] !== 12'h000)
      $display("FAIL wrap_addr: got %h %h required fff 000", re_addr[br], re_addr[br + 1]);
    else passed++;
    checks++;
    if (rq.size() != 2 || rq[0] !== 8'hA5 || rq[1] !== 8'h5A)
      $display("FAIL wrap_data: got %h %h required a5 5a", rq[0], rq[1]);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int t, bw, lat;
    slave_delay = 6'd0;
    send_header(1'b0, 12'h010, 1'b1, 12'd1, 1'b0);
    t = 0;
    @(negedge clk);
    bus.m_valid = 1'b0;
    while (bus.s_valid !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (t >= 50) $display("FAIL rm_wait: s_valid timeout, got %b required 1", bus.s_valid);
    else passed++;
    bus.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    bus.m_ready = 1'b0;
    rstn = 1'b0;
    #1;
    checks++;
    if ({bus.s_ready, bus.s_valid, bus.tx_data, bus.split_enable, mem_we, mem_re, mem_addr, mem_wdata} !== 26'h0)
      $display("FAIL rm_outputs: got %h required 0000000",
               {bus.s_ready, bus.s_valid, bus.tx_data, bus.split_enable, mem_we, mem_re, mem_addr, mem_wdata});
    else passed++;
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    bw = we_addr.size();
    send_header(1'b1, 12'h0AB, 1'b0, 12'h000, 1'b0);
    wq = '{8'h3D};
    write_data();
    repeat (3) @(negedge clk);
    checks++;
    if (we_addr.size() != bw + 1 || we_addr[bw] !== 12'h0AB || we_data[bw] !== 8'h3D)
      $display("FAIL rm_write: got %h=%h required 0ab=3d", we_addr[bw], we_data[bw]);
    else passed++;
    send_header(1'b0, 12'h0AB, 1'b0, 12'h000, 1'b0);
    recv(1, 1'b0, lat);
    checks++;
    if (rq.size() != 1 || rq[0] !== 8'h3D) $display("FAIL rm_readback: got %h required 3d", rq[0]);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

  initial begin
    slave_delay = 6'd0;
    bus.read_enable = 1'b0; bus.write_enable = 1'b0;
    bus.m_valid = 1'b0; bus.m_ready = 1'b0;
    bus.rx_address = 1'b0; bus.rx_burst = 1'b0; bus.rx_data = 1'b0;
    test_reset();
    test_single_write();
    test_read_burst(1'b0);
    test_slow_read();
    test_write_burst();
    test_wrap();
    test_read_burst(1'b1);
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
